ecc_err_log: RTL

- Downstream consumer of the ECC memory stage (test2): samples its per-read error outputs (error_flag, ERRr, error_address, error_data).
- Converts multi-cycle error indications into single de-duplicated error events and buffers them in a show-ahead FIFO for a host/diagnostic reader.
- Keeps saturating statistics counters (corrected, uncorrectable, dropped) plus a sticky overflow flag.

---
 rtl/ecc_err_log.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ecc_err_log.sv
// ----------------------------------------------------------------------------
// ecc_err_log
//
// Purpose:
//   This block sits after the ECC memory stage. It watches the error outputs
//   of each read. An error that stays asserted for several cycles becomes one
//   event. Events are stored in a small show-ahead FIFO for a host or
//   diagnostic reader. Saturating statistics counters and a sticky overflow
//   flag are also kept.
//
// Optional feature:
//   Define ECC_ERR_LOG_TIMESTAMP_EN to enable it. The block then contains a
//   free-running 32-bit cycle counter. Each entry holds the counter value of
//   the cycle in which its event occurred, and that value is output on LOG_TS.
//
// Ports:
//   CLK, RST          clock; synchronous active-high reset
//   error_flag        corrected (single-bit) error on the current read
//   ERRr              uncorrectable error on the current read
//   error_address     address of the erroneous read   [AW]
//   error_data        data word reported with error   [DW]
//   LOG_VALID/READY   show-ahead handshake for the FIFO head
//   LOG_TYPE          head type, 0 = corrected, 1 = uncorrectable
//   LOG_ADDR/DATA     head address / data
//   LOG_COUNT         FIFO occupancy, 0..DEPTH
//   CORR_CNT          corrected event counter (saturating)
//   UNCORR_CNT        uncorrectable event counter (saturating)
//   DROP_CNT          events lost because the FIFO was full (saturating)
//   OVF               sticky overflow
//   CLR               clears the counters and OVF; the FIFO is not affected
//   LOG_TS            head timestamp (only when ECC_ERR_LOG_TIMESTAMP_EN is set)
// ----------------------------------------------------------------------------
module ecc_err_log #(
    parameter int DEPTH = 8,
    parameter int AW    = 14,
    parameter int DW    = 64,
    parameter int CW    = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     error_flag,
    input  logic                     ERRr,
    input  logic [AW-1:0]            error_address,
    input  logic [DW-1:0]            error_data,
    output logic                     LOG_VALID,
    input  logic                     LOG_READY,
    output logic                     LOG_TYPE,
    output logic [AW-1:0]            LOG_ADDR,
    output logic [DW-1:0]            LOG_DATA,
    output logic [$clog2(DEPTH):0]   LOG_COUNT,
    output logic [CW-1:0]            CORR_CNT,
    output logic [CW-1:0]            UNCORR_CNT,
    output logic [CW-1:0]            DROP_CNT,
    output logic                     OVF,
    input  logic                     CLR
`ifdef ECC_ERR_LOG_TIMESTAMP_EN
    ,
    output logic [31:0]              LOG_TS
`endif
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
`ifdef ECC_ERR_LOG_TIMESTAMP_EN
    localparam int TSW  = 32;
`else
    localparam int TSW  = 0;
`endif
    localparam int EW   = TSW + 1 + AW + DW;

    // ---------------- event qualification ----------------
    logic          prev_present_q, prev_type_q;
    logic [AW-1:0] prev_addr_q;
    logic          present, ev_type, ev;

    always_comb begin
        present = error_flag | ERRr;
        ev_type = ERRr;                 // uncorrectable wins when both are set
        // An error that is held on the same address and type is one event.
        ev      = present & (~prev_present_q
                           | (error_address != prev_addr_q)
                           | (ev_type != prev_type_q));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_present_q <= 1'b0;
            prev_type_q    <= 1'b0;
            prev_addr_q    <= '0;
        end else begin
            prev_present_q <= present;
            prev_type_q    <= ev_type;
            prev_addr_q    <= error_address;
        end
    end

    // ---------------- FIFO ----------------
    logic [EW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q, count_d;
    logic            full, pop, push, drop;
    logic [EW-1:0]   entry_d, head;

`ifdef ECC_ERR_LOG_TIMESTAMP_EN
    logic [31:0] ts_q;
    always_ff @(posedge CLK) begin
        if (RST) ts_q <= '0;
        else     ts_q <= ts_q + 32'd1;
    end
    assign entry_d = {ts_q, ev_type, error_address, error_data};
`else
    assign entry_d = {ev_type, error_address, error_data};
`endif

    always_comb begin
        full  = (count_q == CNTW'(DEPTH));
        pop   = LOG_VALID & LOG_READY;
        // When the FIFO is full, a pop in the same cycle makes room for the push.
        push  = ev & (~full | pop);
        drop  = ev & full & ~pop;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // The storage array has no reset. Valid entries are tracked only by the
    // pointers and the count.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= entry_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);   // DEPTH is a power of two
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Show-ahead head. The fields are forced to zero while the FIFO is empty,
    // so the outputs read zero after reset.
    always_comb begin
        LOG_VALID = (count_q != '0);
        LOG_COUNT = count_q;
        head      = LOG_VALID ? mem_q[rd_ptr_q] : '0;
        LOG_DATA  = head[DW-1:0];
        LOG_ADDR  = head[DW +: AW];
        LOG_TYPE  = head[DW+AW];
    end

`ifdef ECC_ERR_LOG_TIMESTAMP_EN
    assign LOG_TS = head[EW-1 -: 32];
`endif

    // ---------------- statistics ----------------
    // Index 0 = corrected, 1 = uncorrectable, 2 = dropped.
    logic [2:0]          stat_inc;
    logic [2:0][CW-1:0]  stat_q, stat_d;
    logic                ovf_q, ovf_d;

    assign stat_inc = {drop, ev & ev_type, ev & ~ev_type};

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        // With CLR, a counter that also increments this cycle restarts at 1.
        assign stat_d[gi] = CLR ? CW'(stat_inc[gi])
                          : (stat_inc[gi] && !(&stat_q[gi])) ? stat_q[gi] + CW'(1)
                          : stat_q[gi];
    end

    assign ovf_d = CLR ? drop : (ovf_q | drop);

    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            stat_q <= stat_d;
            ovf_q  <= ovf_d;
        end
    end

    assign CORR_CNT   = stat_q[0];
    assign UNCORR_CNT = stat_q[1];
    assign DROP_CNT   = stat_q[2];
    assign OVF        = ovf_q;

endmodule
